pipe_hazard_sequencer: RTL and testbench

Sequencing controller for the 4-stage 8-bit pipeline (IR1 fetch, IR2 register read, IR3 execute/memory, IR4 writeback).
- Detects load-use hazards and holds PC and IR1 while bubbles are injected.
- Flushes wrong-path instructions when a branch resolves taken.
- Freezes the pipeline on stop.
- Sits beside the register-file/forwarding control and drives the PC and IR load enables.

---
 rtl/pipe_hazard_sequencer_pkg.sv | 36 +++
 rtl/pipe_hazard_sequencer_instr_src_decode.sv | 52 +++++
 rtl/pipe_hazard_sequencer.sv | 161 ++++++++++++++++
 tb/tb_pipe_hazard_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_sequencer_pkg
// Brief    : Opcode constants and state encodings shared by the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_hazard_sequencer_pkg;

    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_STOP  = 4'b0001;
    localparam logic [3:0] OP_STORE = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_NAND  = 4'b1000;
    localparam logic [3:0] OP_BZ    = 4'b0101;
    localparam logic [3:0] OP_BNZ   = 4'b1001;
    localparam logic [3:0] OP_BPZ   = 4'b1101;
    localparam logic [3:0] OP_NOP   = 4'b1010;

    // Shift is the single nibble 0011 (1011 is undefined); ori matches x111.
    localparam logic [3:0] OP_SHIFT_MASK = 4'b1111;
    localparam logic [3:0] OP_SHIFT_VAL  = 4'b0011;
    localparam logic [3:0] OP_ORI_MASK   = 4'b0111;
    localparam logic [3:0] OP_ORI_VAL    = 4'b0111;

    localparam logic [7:0] NOP_INSTR = 8'h0A;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_sequencer_instr_src_decode.sv
`default_nettype none
// ============================================================================
// Module   : instr_src_decode
// Brief    : Decodes which source registers an instruction reads, plus load/stop.
// Revision : 1.0 - initial release
// ============================================================================
module instr_src_decode
    import pipe_hazard_sequencer_pkg::*;
(
    input  logic [7:0] i_instr,
    output logic       o_reads_a,
    output logic       o_reads_b,
    output logic [1:0] o_src_a,
    output logic [1:0] o_src_b,
    output logic       o_is_load,
    output logic       o_is_stop
);

    logic [3:0] w_op;
    assign w_op = i_instr[3:0];

    always_comb begin
        o_reads_a = 1'b0;
        o_reads_b = 1'b0;
        o_src_a   = i_instr[7:6];
        o_src_b   = i_instr[5:4];
        o_is_load = 1'b0;
        o_is_stop = 1'b0;
        case (w_op)
            OP_ADD, OP_SUB, OP_NAND, OP_STORE: begin
                o_reads_a = 1'b1;
                o_reads_b = 1'b1;
            end
            OP_LOAD: begin
                o_reads_b = 1'b1;
                o_is_load = 1'b1;
            end
            OP_STOP: o_is_stop = 1'b1;
            default: ;
        endcase
        if ((w_op & OP_SHIFT_MASK) == OP_SHIFT_VAL) begin
            o_reads_a = 1'b1;
        end
        // ori implicitly reads r1 regardless of the Rx field
        if ((w_op & OP_ORI_MASK) == OP_ORI_VAL) begin
            o_reads_a = 1'b1;
            o_src_a   = 2'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_sequencer
// Brief    : Load-use stall, branch flush and stop freeze control for the pipe.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_sequencer
    import pipe_hazard_sequencer_pkg::*;
#(
    parameter int LOAD_STALL   = 1,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       IR1Out,
    input  logic [7:0]       IR2Out,
    input  logic [7:0]       IR4Out,
    input  logic             branch_taken,
    output logic             PCWrite,
    output logic             IR1Load,
    output logic             IR1Nop,
    output logic             IR2Nop,
    output logic             Halted,
    output logic [CNT_W-1:0] BubbleCount
);

    localparam logic [1:0] c_STALL_INIT = 2'(LOAD_STALL - 1);
    localparam logic       c_FLUSH_IR2  = (FLUSH_CYCLES == 2);

    state_t             r_state, w_state_next;
    logic [1:0]         r_stall_cnt, w_stall_cnt_next;
    logic [1:0]         w_stall_dec;
    logic [CNT_W-1:0]   r_bubble_cnt;

    logic       w_d1_reads_a, w_d1_reads_b, w_d1_is_load, w_d1_is_stop;
    logic [1:0] w_d1_src_a, w_d1_src_b;
    logic       w_d2_reads_a, w_d2_reads_b, w_d2_is_load, w_d2_is_stop;
    logic [1:0] w_d2_src_a, w_d2_src_b;
    logic       w_d4_reads_a, w_d4_reads_b, w_d4_is_load, w_d4_is_stop;
    logic [1:0] w_d4_src_a, w_d4_src_b;
    logic       w_unused_ok;
    logic       w_run_like, w_hazard;

    instr_src_decode u_dec_ir1 (
        .i_instr   (IR1Out),
        .o_reads_a (w_d1_reads_a),
        .o_reads_b (w_d1_reads_b),
        .o_src_a   (w_d1_src_a),
        .o_src_b   (w_d1_src_b),
        .o_is_load (w_d1_is_load),
        .o_is_stop (w_d1_is_stop)
    );

    instr_src_decode u_dec_ir2 (
        .i_instr   (IR2Out),
        .o_reads_a (w_d2_reads_a),
        .o_reads_b (w_d2_reads_b),
        .o_src_a   (w_d2_src_a),
        .o_src_b   (w_d2_src_b),
        .o_is_load (w_d2_is_load),
        .o_is_stop (w_d2_is_stop)
    );

    instr_src_decode u_dec_ir4 (
        .i_instr   (IR4Out),
        .o_reads_a (w_d4_reads_a),
        .o_reads_b (w_d4_reads_b),
        .o_src_a   (w_d4_src_a),
        .o_src_b   (w_d4_src_b),
        .o_is_load (w_d4_is_load),
        .o_is_stop (w_d4_is_stop)
    );

    assign w_unused_ok = ^{w_d1_is_load, w_d1_is_stop, w_d2_reads_a, w_d2_reads_b,
                           w_d2_src_a, w_d2_src_b, w_d2_is_stop, w_d4_reads_a,
                           w_d4_reads_b, w_d4_src_a, w_d4_src_b, w_d4_is_load};

    // FLUSH behaves exactly like RUN; it only exists as a distinct register state.
    assign w_run_like = (r_state == ST_RUN) || (r_state == ST_FLUSH);
    assign w_hazard   = w_d2_is_load && w_run_like &&
                        ((w_d1_reads_a && (w_d1_src_a == IR2Out[7:6])) ||
                         (w_d1_reads_b && (w_d1_src_b == IR2Out[7:6])));
    assign w_stall_dec = r_stall_cnt - 2'd1;

    always_comb begin
        PCWrite          = 1'b1;
        IR1Load          = 1'b1;
        IR1Nop           = 1'b0;
        IR2Nop           = 1'b0;
        Halted           = 1'b0;
        w_state_next     = r_state;
        w_stall_cnt_next = r_stall_cnt;
        if (!reset) begin
            case (r_state)
                ST_HALT: begin
                    PCWrite = 1'b0;
                    IR1Load = 1'b0;
                    Halted  = 1'b1;
                end
                ST_STALL: begin
                    if (branch_taken) begin
                        IR1Nop           = 1'b1;
                        IR2Nop           = c_FLUSH_IR2;
                        w_state_next     = ST_FLUSH;
                        w_stall_cnt_next = 2'd0;
                    end else begin
                        PCWrite = 1'b0;
                        IR1Load = 1'b0;
                        IR2Nop  = 1'b1;
                        w_stall_cnt_next = w_stall_dec;
                        if (w_stall_dec == 2'd0) begin
                            w_state_next = ST_RUN;
                        end
                    end
                end
                default: begin
                    w_state_next = ST_RUN;
                    if (branch_taken) begin
                        IR1Nop       = 1'b1;
                        IR2Nop       = c_FLUSH_IR2;
                        w_state_next = ST_FLUSH;
                    end else if (w_hazard) begin
                        PCWrite = 1'b0;
                        IR1Load = 1'b0;
                        IR2Nop  = 1'b1;
                        if (LOAD_STALL > 1) begin
                            w_state_next     = ST_STALL;
                            w_stall_cnt_next = c_STALL_INIT;
                        end
                    end
                end
            endcase
            if (w_d4_is_stop && (r_state != ST_HALT)) begin
                w_state_next = ST_HALT;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_stall_cnt <= 2'd0;
        end else begin
            r_state     <= w_state_next;
            r_stall_cnt <= w_stall_cnt_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_bubble_cnt <= '0;
        end else if ((IR1Nop || IR2Nop) && !(&r_bubble_cnt)) begin
            r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

    assign BubbleCount = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_sequencer
// Brief    : Directed self-checking bench for the hazard sequencer (two configs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] IR1Out, IR2Out, IR4Out;
    logic       branch_taken;

    logic        a_pcw, a_ld, a_n1, a_n2, a_h;
    logic [15:0] a_cnt;
    logic        b_pcw, b_ld, b_n1, b_n2, b_h;
    logic [3:0]  b_cnt;
    logic [4:0]  a_outs, b_outs;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    // A: single-bubble load stall, one-stage flush
    pipe_hazard_sequencer #(.LOAD_STALL(1), .FLUSH_CYCLES(1), .CNT_W(16)) u_dut_a (
        .clock(clock), .reset(reset), .IR1Out(IR1Out), .IR2Out(IR2Out),
        .IR4Out(IR4Out), .branch_taken(branch_taken), .PCWrite(a_pcw),
        .IR1Load(a_ld), .IR1Nop(a_n1), .IR2Nop(a_n2), .Halted(a_h),
        .BubbleCount(a_cnt)
    );

    // B: three-bubble load stall, two-stage flush, narrow counter
    pipe_hazard_sequencer #(.LOAD_STALL(3), .FLUSH_CYCLES(2), .CNT_W(4)) u_dut_b (
        .clock(clock), .reset(reset), .IR1Out(IR1Out), .IR2Out(IR2Out),
        .IR4Out(IR4Out), .branch_taken(branch_taken), .PCWrite(b_pcw),
        .IR1Load(b_ld), .IR1Nop(b_n1), .IR2Nop(b_n2), .Halted(b_h),
        .BubbleCount(b_cnt)
    );

    // {PCWrite, IR1Load, IR1Nop, IR2Nop, Halted}
    assign a_outs = {a_pcw, a_ld, a_n1, a_n2, a_h};
    assign b_outs = {b_pcw, b_ld, b_n1, b_n2, b_h};

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic set_idle();
        IR1Out       = 8'h0A;
        IR2Out       = 8'h0A;
        IR4Out       = 8'h0A;
        branch_taken = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic run_vec(input string tag, input logic [7:0] ir2, input logic [7:0] ir1,
                           input logic [4:0] exp);
        IR2Out = ir2;
        IR1Out = ir1;
        @(negedge clock);
        check_val(tag, a_outs, exp);
        next_cycle();
    endtask

    initial begin
        reset = 1'b1;
        set_idle();
        @(negedge clock);
        check_val("rst_outs_a", a_outs, 5'b11000);
        check_val("rst_cnt_a", a_cnt, 0);
        check_val("rst_outs_b", b_outs, 5'b11000);
        next_cycle();
        reset = 1'b0;

        // load r1 followed by add r0,r1
        IR2Out = 8'h40;
        IR1Out = 8'h14;
        @(negedge clock);
        check_val("lu1_stall", a_outs, 5'b00010);
        check_val("lu1_cnt0", a_cnt, 0);
        check_val("lu3_hazard", b_outs, 5'b00010);
        next_cycle();
        IR2Out = 8'h0A;
        @(negedge clock);
        check_val("lu1_resume", a_outs, 5'b11000);
        check_val("lu1_cnt1", a_cnt, 1);
        check_val("lu3_stall1", b_outs, 5'b00010);
        next_cycle();
        @(negedge clock);
        check_val("lu1_cnt_hold", a_cnt, 1);
        check_val("lu3_stall2", b_outs, 5'b00010);
        next_cycle();
        @(negedge clock);
        check_val("lu3_resume", b_outs, 5'b11000);
        check_val("lu3_cnt", b_cnt, 3);

        // decode patterns against load r1 in IR2
        do_reset();
        run_vec("nohz_nop", 8'h40, 8'h2A, 5'b11000);
        run_vec("nohz_ir2add", 8'h44, 8'h14, 5'b11000);
        run_vec("nohz_otherreg", 8'h80, 8'h14, 5'b11000);
        run_vec("nohz_undef", 8'h40, 8'h4B, 5'b11000);
        run_vec("nohz_branch", 8'h40, 8'h55, 5'b11000);
        run_vec("hz_ori", 8'h40, 8'h07, 5'b00010);
        run_vec("hz_shift", 8'h40, 8'h43, 5'b00010);
        run_vec("hz_store", 8'h40, 8'h12, 5'b00010);
        @(negedge clock);
        check_val("pattern_cnt", a_cnt, 3);

        // branch taken during a 3-cycle stall
        do_reset();
        IR2Out = 8'h40;
        IR1Out = 8'h14;
        @(negedge clock);
        check_val("br_hazard_b", b_outs, 5'b00010);
        next_cycle();
        IR2Out       = 8'h0A;
        branch_taken = 1'b1;
        @(negedge clock);
        check_val("br_flush_b", b_outs, 5'b11110);
        check_val("br_flush_a", a_outs, 5'b11100);
        next_cycle();
        branch_taken = 1'b0;
        IR1Out       = 8'h0A;
        @(negedge clock);
        check_val("br_run_b", b_outs, 5'b11000);
        check_val("br_cnt_b", b_cnt, 2);
        check_val("br_cnt_a", a_cnt, 2);
        next_cycle();
        @(negedge clock);
        check_val("br_stay_run_b", b_outs, 5'b11000);
        check_val("br_cnt_hold_b", b_cnt, 2);

        // stop in IR4 alongside a hazard, then frozen
        do_reset();
        IR2Out = 8'h40;
        IR1Out = 8'h14;
        IR4Out = 8'h01;
        @(negedge clock);
        check_val("stop_pre", a_outs, 5'b00010);
        next_cycle();
        IR2Out       = 8'h0A;
        IR4Out       = 8'h0A;
        branch_taken = 1'b1;
        @(negedge clock);
        check_val("halt_outs", a_outs, 5'b00001);
        check_val("halt_cnt", a_cnt, 1);
        next_cycle();
        branch_taken = 1'b0;
        IR2Out       = 8'h40;
        @(negedge clock);
        check_val("halt_hazard_ign", a_outs, 5'b00001);
        next_cycle();
        branch_taken = 1'b1;
        @(negedge clock);
        check_val("halt_cnt_frozen", a_cnt, 1);
        #1;
        reset = 1'b1;
        #1;
        check_val("halt_rst_outs", a_outs, 5'b11000);
        check_val("halt_rst_cnt", a_cnt, 0);
        set_idle();
        next_cycle();
        reset = 1'b0;

        // continuous hazard saturates the 4-bit counter
        do_reset();
        IR2Out = 8'h40;
        IR1Out = 8'h14;
        repeat (14) next_cycle();
        @(negedge clock);
        check_val("sat_cnt14", b_cnt, 4'hE);
        repeat (6) next_cycle();
        @(negedge clock);
        check_val("sat_cnt20", b_cnt, 4'hF);
        check_val("sat_outs", b_outs, 5'b00010);

        // asynchronous reset between edges while stalled
        do_reset();
        IR2Out = 8'h40;
        IR1Out = 8'h14;
        next_cycle();
        IR2Out = 8'h0A;
        @(negedge clock);
        check_val("arst_in_stall", b_outs, 5'b00010);
        #1;
        reset = 1'b1;
        #1;
        check_val("arst_outs", b_outs, 5'b11000);
        check_val("arst_cnt", b_cnt, 0);
        next_cycle();
        reset = 1'b0;
        @(negedge clock);
        check_val("arst_run", b_outs, 5'b11000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
